branch_predictor_bht: RTL

//  Parametrised bimodal branch predictor for the InsFetch stage; successor of the fixed pc+4 predictor.

---
 rtl/branch_predictor_bht_pkg.sv | 40 ++++
 rtl/branch_predictor_bht_if.sv | 27 ++
 rtl/branch_predictor_bht_counter_table.sv | 32 +++
 rtl/branch_predictor_bht.sv | 89 ++++++++
 4 files changed

// File: rtl/branch_predictor_bht_pkg.sv
// rtl/branch_predictor_bht_pkg.sv - shared opcodes, counter constants and helpers for the bimodal predictor
package branch_predictor_bht_pkg;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    // Weakly not-taken: one taken commit is enough to flip the prediction.
    localparam logic [1:0] CNT_RESET = 2'b01;

    typedef enum logic [1:0] {
        INS_OTHER  = 2'd0,
        INS_JAL    = 2'd1,
        INS_BRANCH = 2'd2,
        INS_JALR   = 2'd3
    } ins_kind_e;

    function automatic ins_kind_e decode_kind(input logic [6:0] opcode);
        ins_kind_e kind;
        case (opcode)
            OPCODE_JAL:    kind = INS_JAL;
            OPCODE_BRANCH: kind = INS_BRANCH;
            OPCODE_JALR:   kind = INS_JALR;
            default:       kind = INS_OTHER;
        endcase
        return kind;
    endfunction

    // 2-bit saturating counter step toward the committed outcome.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != 2'b11)
            nxt = cnt + 2'b01;
        else if (!taken && cnt != 2'b00)
            nxt = cnt - 2'b01;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// rtl/branch_predictor_bht_if.sv - fetch-side prediction and ROB-side training signals
interface branch_predictor_bht_if #(
    parameter int ADDR_W = 32,
    parameter int INS_W  = 32
);
    logic              rdy;
    logic [ADDR_W-1:0] pc_cur;
    logic [INS_W-1:0]  ins_cur;
    logic              pc_pred_enable;
    logic [ADDR_W-1:0] pc_pred;
    logic              predict_jump_to_dispatcher;
    logic              enable_from_rob;
    logic              if_jump;
    logic [ADDR_W-1:0] pc_finish;

    // Fetch stage / ROB side: supplies PC, instruction and commit outcomes.
    modport master (
        output rdy, pc_cur, ins_cur, enable_from_rob, if_jump, pc_finish,
        input  pc_pred_enable, pc_pred, predict_jump_to_dispatcher
    );

    // Predictor side.
    modport slave (
        input  rdy, pc_cur, ins_cur, enable_from_rob, if_jump, pc_finish,
        output pc_pred_enable, pc_pred, predict_jump_to_dispatcher
    );
endinterface

// File: rtl/branch_predictor_bht_counter_table.sv
// rtl/branch_predictor_bht_counter_table.sv - 2^INDEX_BITS x 2-bit saturating counter array
module bp_counter_table
    import branch_predictor_bht_pkg::*;
#(
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic [1:0]            rd_cnt,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  wr_taken
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0] cnt [ENTRIES];

    // Counter storage: async re-init to weakly not-taken, one saturating update per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt[i] <= CNT_RESET;
        end else if (wr_en) begin
            cnt[wr_idx] <= sat_update(cnt[wr_idx], wr_taken);
        end
    end

    // Read is asynchronous so a same-cycle update is seen only from the next cycle.
    assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - bimodal branch predictor for fetch; BP_GSHARE_EN adds global-history hashing
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int INS_W      = 32,
    parameter int INDEX_BITS = 8,
    parameter int HIST_BITS  = 8
) (
    input logic                   clk,
    input logic                   rst,
    branch_predictor_bht_if.slave bus
);
    logic [INDEX_BITS-1:0] idx_p;
    logic [INDEX_BITS-1:0] idx_t;
    logic [1:0]            rd_cnt;
    logic                  train_en;
    ins_kind_e             kind;
    logic [ADDR_W-1:0]     imm_j;
    logic [ADDR_W-1:0]     imm_b;
    logic [ADDR_W-1:0]     pc_seq;

    assign train_en = bus.rdy & bus.enable_from_rob;

`ifdef BP_GSHARE_EN
    logic [HIST_BITS-1:0] ghr;

    // Commit-time global history: only accepted training strobes shift it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ghr <= '0;
        else if (train_en)
            ghr <= (ghr << 1) | HIST_BITS'(bus.if_jump);
    end

    // Both ports hash with the pre-shift history.
    assign idx_p = bus.pc_cur[INDEX_BITS+1:2]    ^ INDEX_BITS'(ghr);
    assign idx_t = bus.pc_finish[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
`else
    assign idx_p = bus.pc_cur[INDEX_BITS+1:2];
    assign idx_t = bus.pc_finish[INDEX_BITS+1:2];
`endif

    bp_counter_table #(
        .INDEX_BITS (INDEX_BITS)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx_p),
        .rd_cnt   (rd_cnt),
        .wr_en    (train_en),
        .wr_idx   (idx_t),
        .wr_taken (bus.if_jump)
    );

    assign kind   = decode_kind(bus.ins_cur[6:0]);
    assign pc_seq = bus.pc_cur + ADDR_W'(4);

    assign imm_j = {{(ADDR_W-21){bus.ins_cur[31]}}, bus.ins_cur[31], bus.ins_cur[19:12],
                    bus.ins_cur[20], bus.ins_cur[30:21], 1'b0};
    assign imm_b = {{(ADDR_W-13){bus.ins_cur[31]}}, bus.ins_cur[31], bus.ins_cur[7],
                    bus.ins_cur[30:25], bus.ins_cur[11:8], 1'b0};

    // Zero-latency next-PC selection from the decoded opcode and counter MSB.
    always_comb begin
        bus.predict_jump_to_dispatcher = 1'b0;
        bus.pc_pred                    = pc_seq;
        case (kind)
            INS_JAL: begin
                bus.predict_jump_to_dispatcher = 1'b1;
                bus.pc_pred                    = bus.pc_cur + imm_j;
            end
            INS_BRANCH: begin
                if (rd_cnt[1]) begin
                    bus.predict_jump_to_dispatcher = 1'b1;
                    bus.pc_pred                    = bus.pc_cur + imm_b;
                end
            end
            default: ;
        endcase
    end

    assign bus.pc_pred_enable = ~rst;

    // Operand bits that carry no prediction information.
    logic unused_bits;
    assign unused_bits = (^{bus.pc_finish, bus.ins_cur, rd_cnt[0]}) ^ (HIST_BITS > INDEX_BITS);

endmodule
